// File: rtl/fetch_pc.sv
// Fetch-stage program counter: conditional/relative branches, absolute jump,
// call/return through a circular return-address stack, and a decode flush pulse.
module fetch_pc #(
    parameter int unsigned       PC_W      = 16,
    parameter int unsigned       OFS_W     = 8,
    parameter int unsigned       CMP_W     = 8,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter logic [PC_W-1:0]   RESET_PC  = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           halt,
    input  logic                           branch,
    input  logic [2:0]                     br_mode,
    input  logic [CMP_W-1:0]               cmp,
    input  logic [OFS_W-1:0]               offset,
    input  logic [PC_W-1:0]                target,
    output logic [PC_W-1:0]                pc,
    output logic                           taken,
    output logic                           flush,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_ovf,
    output logic                           ras_unf
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        M_BLT  = 3'b000,
        M_BNE  = 3'b001,
        M_BEQ  = 3'b010,
        M_BGE  = 3'b011,
        M_JMP  = 3'b100,
        M_CALL = 3'b101,
        M_RET  = 3'b110,
        M_JABS = 3'b111
    } br_mode_e;

    br_mode_e           mode;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               flush_q;
    logic [PC_W-1:0]    ras_q [RAS_DEPTH];
    logic               ras_we;
    logic [PC_W-1:0]    seq_pc, rel_pc, ras_top;
    logic               ras_empty, ras_full, cond;

    assign mode      = br_mode_e'(br_mode);
    assign seq_pc    = pc_q + PC_W'(1);
    assign rel_pc    = pc_q + PC_W'($signed(offset));
    assign ras_top   = ras_q[ptr_q - PTR_W'(1)];
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

    always_comb begin
        cond = 1'b0;
        unique case (mode)
            M_BLT:   cond = cmp[CMP_W-1];
            M_BNE:   cond = (cmp != '0);
            M_BEQ:   cond = (cmp == '0);
            M_BGE:   cond = !cmp[CMP_W-1];
            M_RET:   cond = !ras_empty;
            default: cond = 1'b1;
        endcase
    end

    assign taken = branch && !halt && cond;

    always_comb begin
        pc_d   = pc_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        ras_we = 1'b0;
        if (!halt) begin
            pc_d = seq_pc;
            if (taken) begin
                unique case (mode)
                    M_JABS:  pc_d = target;
                    M_RET:   pc_d = ras_top;
                    default: pc_d = rel_pc;
                endcase
            end
            // A full stack keeps its count; the write pointer wrapping onto the oldest entry overwrites it.
            if (branch && mode == M_CALL) begin
                ras_we = 1'b1;
                ptr_d  = ptr_q + PTR_W'(1);
                if (ras_full) ovf_d = 1'b1;
                else          cnt_d = cnt_q + CNT_W'(1);
            end
            if (branch && mode == M_RET) begin
                if (ras_empty) begin
                    unf_d = 1'b1;
                end else begin
                    ptr_d = ptr_q - PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            flush_q <= taken;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_we && reset) ras_q[ptr_q] <= seq_pc;
    end

    assign pc        = pc_q;
    assign flush     = flush_q;
    assign ras_count = cnt_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Scoreboard bench for fetch_pc: expected pc/flush/ras_count are queued as
// stimulus is driven and compared after the following clock edge.
module tb_fetch_pc;

    localparam logic [2:0] BLT = 3'b000, BNE = 3'b001, BEQ = 3'b010, BGE = 3'b011;
    localparam logic [2:0] CALL = 3'b101, RET = 3'b110, JABS = 3'b111;

    logic        clk, reset, halt, branch;
    logic [2:0]  br_mode;
    logic [7:0]  cmp, offset;
    logic [15:0] target, pc;
    logic        taken, flush, ras_ovf, ras_unf;
    logic [2:0]  ras_count;

    typedef struct {
        logic [15:0] pc;
        logic        flush;
        logic [2:0]  cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    fetch_pc #(.PC_W(16), .OFS_W(8), .CMP_W(8), .RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .halt(halt), .branch(branch), .br_mode(br_mode),
        .cmp(cmp), .offset(offset), .target(target), .pc(pc), .taken(taken),
        .flush(flush), .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input logic [15:0] addr);
        branch = 1'b1; br_mode = JABS; target = addr;
        tick();
        branch = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({pc, flush, ras_count, ras_ovf, ras_unf} !== {16'h0000, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got pc=%h flush=%b cnt=%0d ovf=%b unf=%b, expected 0000 0 0 0 0",
                     pc, flush, ras_count, ras_ovf, ras_unf);
        end
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            sb.push_back('{pc: 16'(i), flush: 1'b0, cnt: 3'd0});
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc, flush, ras_count} !== {e.pc, e.flush, e.cnt}) begin
                errors++;
                $display("FAIL seq_step%0d: got pc=%h flush=%b cnt=%0d, expected %h %b %0d",
                         i, pc, flush, ras_count, e.pc, e.flush, e.cnt);
            end
        end
    endtask

    task automatic test_wrap();
        goto(16'hFFFF);
        sb.push_back('{pc: 16'h0000, flush: 1'b0, cnt: 3'd0});
        tick();
        e = sb.pop_front();
        checks++;
        if ({pc, flush, ras_count} !== {e.pc, e.flush, e.cnt}) begin
            errors++;
            $display("FAIL wrap: got pc=%h flush=%b cnt=%0d, expected %h %b %0d",
                     pc, flush, ras_count, e.pc, e.flush, e.cnt);
        end
    endtask

    task automatic test_cond();
        logic [2:0]  modes [8] = '{BLT, BLT, BGE, BEQ, BNE, BNE, BEQ, BGE};
        logic [7:0]  cmps  [8] = '{8'hFF, 8'h00, 8'h00, 8'h05, 8'h05, 8'h00, 8'h00, 8'h80};
        logic [15:0] pcs   [8] = '{16'd7, 16'd11, 16'd7, 16'd11, 16'd7, 16'd11, 16'd7, 16'd11};
        logic        tks   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            goto(16'd10);
            branch = 1'b1; br_mode = modes[i]; cmp = cmps[i]; offset = 8'hFD;
            #1;
            checks++;
            if (taken !== tks[i]) begin
                errors++;
                $display("FAIL cond%0d_taken: got %b, expected %b", i, taken, tks[i]);
            end
            sb.push_back('{pc: pcs[i], flush: tks[i], cnt: 3'd0});
            tick();
            branch = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({pc, flush, ras_count} !== {e.pc, e.flush, e.cnt}) begin
                errors++;
                $display("FAIL cond%0d: got pc=%h flush=%b cnt=%0d, expected %h %b %0d",
                         i, pc, flush, ras_count, e.pc, e.flush, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        goto(16'd20);
        branch = 1'b1; br_mode = CALL; offset = 8'd30;
        sb.push_back('{pc: 16'd50, flush: 1'b1, cnt: 3'd1});
        tick();
        e = sb.pop_front();
        checks++;
        if ({pc, flush, ras_count} !== {e.pc, e.flush, e.cnt}) begin
            errors++;
            $display("FAIL call: got pc=%h flush=%b cnt=%0d, expected %h %b %0d",
                     pc, flush, ras_count, e.pc, e.flush, e.cnt);
        end
        br_mode = RET;
        sb.push_back('{pc: 16'd21, flush: 1'b1, cnt: 3'd0});
        tick();
        branch = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({pc, flush, ras_count, ras_unf} !== {e.pc, e.flush, e.cnt, 1'b0}) begin
            errors++;
            $display("FAIL ret: got pc=%h flush=%b cnt=%0d unf=%b, expected %h %b %0d 0",
                     pc, flush, ras_count, ras_unf, e.pc, e.flush, e.cnt);
        end
    endtask

    task automatic test_ras_overflow();
        for (int p = 1; p <= 5; p++) begin
            goto(16'(p));
            branch = 1'b1; br_mode = CALL; offset = 8'd0;
            sb.push_back('{pc: 16'(p), flush: 1'b1, cnt: 3'((p < 4) ? p : 4)});
            tick();
            branch = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({pc, flush, ras_count, ras_ovf} !== {e.pc, e.flush, e.cnt, (p == 5)}) begin
                errors++;
                $display("FAIL ovf_call%0d: got pc=%h flush=%b cnt=%0d ovf=%b, expected %h %b %0d %b",
                         p, pc, flush, ras_count, ras_ovf, e.pc, e.flush, e.cnt, (p == 5));
            end
        end
        branch = 1'b1; br_mode = RET;
        for (int k = 0; k < 4; k++) sb.push_back('{pc: 16'(6 - k), flush: 1'b1, cnt: 3'(3 - k)});
        sb.push_back('{pc: 16'd4, flush: 1'b0, cnt: 3'd0});
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                #1;
                checks++;
                if (taken !== 1'b0) begin
                    errors++;
                    $display("FAIL ret_empty_taken: got %b, expected 0", taken);
                end
            end
            tick();
            e = sb.pop_front();
            checks++;
            if ({pc, flush, ras_count, ras_unf} !== {e.pc, e.flush, e.cnt, (k == 4)}) begin
                errors++;
                $display("FAIL ovf_ret%0d: got pc=%h flush=%b cnt=%0d unf=%b, expected %h %b %0d %b",
                         k, pc, flush, ras_count, ras_unf, e.pc, e.flush, e.cnt, (k == 4));
            end
        end
        branch = 1'b0;
    endtask

    task automatic test_halt();
        goto(16'd100);
        halt = 1'b1; branch = 1'b1; br_mode = JABS; target = 16'h1234;
        #1;
        checks++;
        if (taken !== 1'b0) begin
            errors++;
            $display("FAIL halt_taken: got %b, expected 0", taken);
        end
        sb.push_back('{pc: 16'd100, flush: 1'b0, cnt: 3'd0});
        sb.push_back('{pc: 16'h1234, flush: 1'b1, cnt: 3'd0});
        for (int k = 0; k < 2; k++) begin
            tick();
            halt = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({pc, flush, ras_count} !== {e.pc, e.flush, e.cnt}) begin
                errors++;
                $display("FAIL halt%0d: got pc=%h flush=%b cnt=%0d, expected %h %b %0d",
                         k, pc, flush, ras_count, e.pc, e.flush, e.cnt);
            end
        end
        branch = 1'b0;
    endtask

    task automatic test_async_reset();
        goto(16'd30);
        branch = 1'b1; br_mode = CALL; offset = 8'd10;
        sb.push_back('{pc: 16'd40, flush: 1'b1, cnt: 3'd1});
        tick();
        e = sb.pop_front();
        checks++;
        if ({pc, flush, ras_count} !== {e.pc, e.flush, e.cnt}) begin
            errors++;
            $display("FAIL areset_setup: got pc=%h flush=%b cnt=%0d, expected %h %b %0d",
                     pc, flush, ras_count, e.pc, e.flush, e.cnt);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({pc, flush, ras_count, ras_ovf, ras_unf} !== {16'h0000, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL areset_immediate: got pc=%h flush=%b cnt=%0d ovf=%b unf=%b, expected 0000 0 0 0 0",
                     pc, flush, ras_count, ras_ovf, ras_unf);
        end
        tick();
        checks++;
        if ({pc, flush, ras_count} !== {16'h0000, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL areset_hold: got pc=%h flush=%b cnt=%0d, expected 0000 0 0", pc, flush, ras_count);
        end
        branch = 1'b0; reset = 1'b1;
        sb.push_back('{pc: 16'd1, flush: 1'b0, cnt: 3'd0});
        tick();
        e = sb.pop_front();
        checks++;
        if ({pc, flush, ras_count} !== {e.pc, e.flush, e.cnt}) begin
            errors++;
            $display("FAIL areset_release: got pc=%h flush=%b cnt=%0d, expected %h %b %0d",
                     pc, flush, ras_count, e.pc, e.flush, e.cnt);
        end
    endtask

    initial begin
        reset = 1'b0; halt = 1'b0; branch = 1'b0; br_mode = 3'b000;
        cmp = '0; offset = '0; target = '0;
        test_reset();
        test_wrap();
        test_cond();
        test_back_to_back();
        test_ras_overflow();
        test_halt();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Parametrised program-counter unit for the fetch stage. It generalises the single-mode relative-branch counter:
- configurable PC, offset and compare widths;
- eight branch modes, including absolute jump, call and return;
- a return-address stack (RAS) of configurable depth;
- sticky error flags and a one-cycle flush pulse for the decode stage.

It sits between instruction memory addressing (drives `pc`) and the execute/branch logic (supplies `branch`, `br_mode`, `cmp`, `offset`, `target`).

## Interface
- PC_W, 16, width of `pc` and `target`
- OFS_W, 8, width of signed relative `offset`; must be ≤ PC_W
- CMP_W, 8, width of signed compare result `cmp`
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥ 2
- RESET_PC, 0, value loaded into `pc` on reset
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- halt  input  1  freeze all state while high
- branch  input  1  current instruction is a control-flow instruction
- br_mode  input  3  000 BLT, 001 BNE, 010 BEQ, 011 BGE, 100 JMP (relative), 101 CALL (relative + push), 110 RET (pop), 111 JABS (absolute)
- cmp  input  CMP_W  signed compare result
- offset  input  OFS_W  signed relative displacement
- target  input  PC_W  absolute jump target (JABS only)
- pc  output  PC_W  current fetch address
- taken  output  1  combinational; branch taken this cycle
- flush  output  1  registered; high for one cycle after a taken branch
- ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_ovf  output  1  sticky; a CALL was made while the RAS was full
- ras_unf  output  1  sticky; a RET was made while the RAS was empty

## Operation
- Priority each cycle: reset > halt > branch > sequential advance.
- Reset (reset = 0, asynchronous) sets:
  - `pc` = RESET_PC;
  - `flush` = 0, `ras_count` = 0, `ras_ovf` = 0, `ras_unf` = 0;
  - RAS contents don't-care.
- Halt: `pc`, RAS, `ras_count` and the flags all hold. `taken` is forced to 0. `flush` is driven to 0 on the next edge.
- Sequential advance, when no branch: `pc` <= `pc` + 1, modulo 2^PC_W (all-ones wraps to 0).
- Condition evaluation, with `cmp` signed:
  - BLT taken iff `cmp` < 0
  - BNE taken iff `cmp` != 0
  - BEQ taken iff `cmp` == 0
  - BGE taken iff `cmp` >= 0
  - JMP, CALL and JABS are always taken.
  - RET is taken iff `ras_count` > 0.
- Next PC when taken:
  - Relative modes (BLT, BNE, BEQ, BGE, JMP, CALL): `pc` + sign-extend(`offset`), modulo 2^PC_W.
  - JABS: `target`.
  - RET: top RAS entry.
- Not taken: `pc` + 1.
- CALL:
  - Pushes `pc` + 1 (mod 2^PC_W) and increments `ras_count`.
  - When full (`ras_count` == RAS_DEPTH), the oldest entry is overwritten (circular buffer) and `ras_count` stays at RAS_DEPTH. `ras_ovf` sets.
- RET:
  - Pops the top entry and decrements `ras_count`.
  - When empty, `pc` <= `pc` + 1, `taken` = 0, `ras_unf` sets and `ras_count` stays 0.
- `ras_ovf` and `ras_unf` clear only on reset.
- `br_mode` is ignored when `branch` = 0.

## Timing
- `pc` updates on the rising edge of `clk`. The new value is visible in the cycle after the instruction that caused it.
- `taken` is combinational from `branch`, `br_mode`, `cmp`, `halt` and `ras_count` in the same cycle.
- `flush` is a registered copy of `taken`. It is high in exactly the cycle in which the redirected `pc` is first presented.
- Back-to-back taken branches produce consecutive `flush` cycles.
- RAS push/pop, `ras_count` and the flags update on the same edge as `pc`.
- Back-to-back CALL then RET returns to the CALL address + 1 in two cycles.
- Reset asserted mid-operation:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - Deassertion is sampled synchronously; the first advance is on the first rising edge with reset = 1.
- Halt released: advancing resumes from the held `pc` on the next edge. A branch presented in the release cycle is honoured.

## Test plan
- Reset then 5 cycles, no branch (PC_W = 16): `pc` steps 0,1,2,3,4,5. With `pc` = 16'hFFFF and no branch, next `pc` = 0.
- Conditional modes at `pc` = 10, `offset` = −3:
  - BLT with `cmp` = −1: `pc` = 7, `taken` = 1, `flush` = 1 in the next cycle.
  - BLT with `cmp` = 0: `pc` = 11.
  - BGE with `cmp` = 0: `pc` = 7.
  - BEQ with `cmp` = 5: `pc` = 11.
- CALL at `pc` = 20 with `offset` = 30: `pc` = 50, `ras_count` = 1. Then RET: `pc` = 21, `ras_count` = 0, `ras_unf` = 0.
- RAS_DEPTH = 4, five CALLs from `pc` = 1,2,3,4,5 (each `offset` = 0): `ras_ovf` = 1, `ras_count` = 4. Four RETs return 6,5,4,3. A fifth RET gives `pc` + 1 and `ras_unf` = 1.
- JABS with `target` = 16'h1234 while `halt` = 1: `pc` holds and `flush` = 0. Release `halt` with the same inputs: next `pc` = 16'h1234.
- Reset asserted asynchronously between edges while `pc` = 40 with a CALL pending: `pc` = RESET_PC immediately, `ras_count` = 0, flags = 0, no push.
